fetch_stall_ctrl: RTL

//  Fetch-stage sequencer: drives PC hold, IF/ID stall and IF/ID flush from icache hit/miss,

---
 rtl/riscv_fetch_pkg.sv | 26 ++
 rtl/icache_refill_fsm.sv | 104 ++++++++++
 rtl/fetch_stall_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/riscv_fetch_pkg.sv
// ---------------------------------------------------------------------------
// riscv_fetch_pkg
// Shared types and constants for the fetch-stage sequencer.
//   fetch_state_e  : icache refill sequencer state {IDLE, REQ, FILL, DONE}
//   LINE_WORDS_DEF : default number of 32-bit words per icache line
//   BYTE_OFF       : byte-offset bits inside a 32-bit word
//   line_off_w()   : number of low address bits covered by one line
// ---------------------------------------------------------------------------
package riscv_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } fetch_state_e;

    localparam int LINE_WORDS_DEF = 4;
    localparam int BYTE_OFF       = 2;

    // Word-index bits plus byte-offset bits: everything cleared to line-align.
    function automatic int line_off_w(input int words);
        return $clog2(words) + BYTE_OFF;
    endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// ---------------------------------------------------------------------------
// icache_refill_fsm
// Runs the icache line-refill handshake with memory.
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   pc_addr       : current fetch PC (byte address)
//   ic_hit        : icache hit for pc_addr this cycle
//   br_taken      : EX redirect this cycle (suppresses starting a refill)
//   mem_gnt       : memory accepted the refill request (used in REQ only)
//   mem_rvalid    : one refill word valid (used in FILL only)
//   state         : current sequencer state
//   miss_start    : a new miss is being accepted this cycle (IDLE only)
//   mem_req       : refill request valid (registered)
//   mem_addr      : line-aligned refill address (registered)
//   fill_we       : write current refill word into the icache
//   fill_idx      : word index within the line for fill_we (registered)
// Handshake: the request is held with a stable address from the cycle after
// the miss until mem_gnt is seen high in REQ; each mem_rvalid in FILL
// delivers exactly one word, in index order, with any number of idle gaps.
// ---------------------------------------------------------------------------
module icache_refill_fsm
    import riscv_fetch_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_W-1:0]             pc_addr,
    input  logic                          ic_hit,
    input  logic                          br_taken,
    input  logic                          mem_gnt,
    input  logic                          mem_rvalid,
    output fetch_state_e                  state,
    output logic                          miss_start,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          fill_we,
    output logic [$clog2(LINE_WORDS)-1:0] fill_idx
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF_W = line_off_w(LINE_WORDS);

    fetch_state_e       r_state;
    logic               r_mem_req;
    logic [IDX_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]  r_line_addr;
    logic               w_last_word;

    // A miss that coincides with a redirect is for a PC that is being abandoned.
    assign miss_start  = (r_state == IDLE) & ~ic_hit & ~br_taken;
    assign w_last_word = (r_cnt == IDX_W'(LINE_WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_cnt       <= '0;
            r_line_addr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (miss_start) begin
                        r_line_addr <= {pc_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        r_mem_req   <= 1'b1;
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= FILL;
                    end
                end
                FILL: begin
                    if (mem_rvalid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last_word) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Stall is still held this cycle; the next IDLE cycle looks up
                    // whatever PC is current then (possibly a redirected one).
                    r_state <= IDLE;
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign state    = r_state;
    assign mem_req  = r_mem_req;
    assign mem_addr = r_line_addr;
    assign fill_idx = r_cnt;
    assign fill_we  = (r_state == FILL) & mem_rvalid;

endmodule

// File: rtl/fetch_stall_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_stall_ctrl
// Fetch-stage sequencer: PC hold, IF/ID stall and IF/ID flush from icache
// hit/miss, load-use hazard and EX branch redirect, plus the icache refill
// handshake (delegated to icache_refill_fsm) and a saturating miss counter.
// Ports:
//   clk, rst             : clock (rising edge), asynchronous active-high reset
//   pc_addr              : current fetch PC (byte address)
//   ic_hit               : icache hit for pc_addr (combinational, same cycle)
//   load_use             : decode-stage load-use hazard
//   br_taken             : EX taken branch/jump, PC loads target this cycle
//   mem_req / mem_addr   : refill request valid / line-aligned address
//   mem_gnt / mem_rvalid : memory accepted request / one refill word valid
//   fill_we / fill_idx   : icache refill write strobe / word index
//   pc_stall             : hold PC (feeds PC register enable, 1 = hold)
//   ifid_stall           : hold IF/ID register
//   ifid_flush           : load bubble into IF/ID
//   miss_cnt             : saturating count of accepted icache misses
// Priority: br_taken > load_use > miss. A redirect during a refill releases
// the PC for that cycle only; the refill itself always completes.
// ---------------------------------------------------------------------------
module fetch_stall_ctrl
    import riscv_fetch_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_W-1:0]             pc_addr,
    input  logic                          ic_hit,
    input  logic                          load_use,
    input  logic                          br_taken,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_gnt,
    input  logic                          mem_rvalid,
    output logic                          fill_we,
    output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
    output logic                          pc_stall,
    output logic                          ifid_stall,
    output logic                          ifid_flush,
    output logic [CNT_W-1:0]              miss_cnt
);

    fetch_state_e      w_state;
    logic              w_miss_start;
    logic              w_miss_busy;
    logic [CNT_W-1:0]  r_miss_cnt;

    icache_refill_fsm #(
        .ADDR_W     (ADDR_W),
        .LINE_WORDS (LINE_WORDS)
    ) u_refill (
        .clk        (clk),
        .rst        (rst),
        .pc_addr    (pc_addr),
        .ic_hit     (ic_hit),
        .br_taken   (br_taken),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .state      (w_state),
        .miss_start (w_miss_start),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .fill_we    (fill_we),
        .fill_idx   (fill_idx)
    );

    // Busy from the miss cycle itself (IDLE, no hit) through DONE.
    assign w_miss_busy = ((w_state == IDLE) & ~ic_hit) | (w_state != IDLE);

    // All stall/flush outputs are forced low while reset is asserted.
    assign pc_stall   = ~rst & ~br_taken & (load_use | w_miss_busy);
    assign ifid_stall = ~rst & ~br_taken & load_use;
    assign ifid_flush = ~rst & (br_taken | (~load_use & w_miss_busy));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_miss_cnt <= '0;
        end else if (w_miss_start && (r_miss_cnt != {CNT_W{1'b1}})) begin
            r_miss_cnt <= r_miss_cnt + 1'b1;
        end
    end

    assign miss_cnt = r_miss_cnt;

endmodule
